// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// - MEM_*_WIDTH : default bus widths, matching the data memory's MEM_* defines
// - M_CORE/M_AUX: master indices (0 = core data port, 1 = loader/DMA/debug)
package dmem_arbiter_pkg;
  localparam int   MEM_ADDR_WIDTH     = 10;
  localparam int   MEM_DATA_WIDTH     = 32;
  localparam int   MEM_TRANSFER_WIDTH = 4;
  localparam logic M_CORE             = 1'b0;
  localparam logic M_AUX              = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with lock override.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req[1:0]    : per-master request
//   lock_valid  : a lock owner is recorded
//   lock_owner  : index of the lock owner
//   lock_ok     : owner still has lock budget left
//   grant       : some master is granted this cycle (combinational)
//   winner      : index of the granted master (meaningful only with grant)
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock_valid,
  input  logic       lock_owner,
  input  logic       lock_ok,
  output logic       grant,
  output logic       winner
);
  logic rr_last;

  // No grants are issued while reset is asserted.
  always_comb begin
    grant = (|req) & ~rst;
    if (lock_valid && req[lock_owner] && lock_ok)
      winner = lock_owner;
    else if (req == 2'b01)
      winner = M_CORE;
    else if (req == 2'b10)
      winner = M_AUX;
    else
      winner = ~rr_last;
  end

  // rr_last starts at M_AUX so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)        rr_last <= M_AUX;
    else if (grant) rr_last <= winner;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core (m0) and a secondary
// master (m1) with req/gnt/rvalid handshakes, round-robin arbitration, a
// bounded bus lock and a one-stage response pipeline.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mN_req/we/addr/wdata/be  : master request payload (held until gnt)
//   mN_lock_i                : keep ownership for the next transfer
//   mN_gnt_o                 : request accepted this cycle (combinational)
//   mN_rvalid_o, mN_rdata_o  : response, one cycle after gnt
//   mem_*                    : data memory port (registered 1-cycle read)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int TRANSFER_WIDTH = MEM_TRANSFER_WIDTH,
  parameter int MAX_LOCK       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req_i,
  input  logic                      m0_we_i,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] m0_be_i,
  input  logic                      m0_lock_i,
  output logic                      m0_gnt_o,
  output logic                      m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  input  logic                      m1_req_i,
  input  logic                      m1_we_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] m1_be_i,
  input  logic                      m1_lock_i,
  output logic                      m1_gnt_o,
  output logic                      m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  logic       grant, winner;
  logic       lock_valid, lock_owner;
  logic [7:0] lock_cnt, lock_base;
  logic       resp_valid, resp_owner;
  logic       w_we, w_lock, other_req;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1_req_i, m0_req_i}),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .lock_ok    (lock_cnt < LOCK_MAX),
    .grant      (grant),
    .winner     (winner)
  );

  assign w_we      = (winner == M_AUX) ? m1_we_i   : m0_we_i;
  assign w_lock    = (winner == M_AUX) ? m1_lock_i : m0_lock_i;
  assign other_req = (winner == M_AUX) ? m0_req_i  : m1_req_i;

  assign m0_gnt_o = grant & (winner == M_CORE);
  assign m1_gnt_o = grant & (winner == M_AUX);

  // Memory side is quiet (all zero) whenever nothing is granted.
  assign mem_we_o    = grant & w_we;
  assign mem_addr_o  = !grant ? '0 : (winner == M_AUX) ? m1_addr_i  : m0_addr_i;
  assign mem_wdata_o = !grant ? '0 : (winner == M_AUX) ? m1_wdata_i : m0_wdata_i;
  assign mem_be_o    = !grant ? '0 : (winner == M_AUX) ? m1_be_i    : m0_be_i;

  // A new owner starts its budget from zero; the running owner continues.
  assign lock_base = (lock_valid && lock_owner == winner) ? lock_cnt : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_owner <= M_CORE;
      lock_valid <= 1'b0;
      lock_owner <= M_CORE;
      lock_cnt   <= 8'd0;
    end else begin
      resp_valid <= grant;
      if (grant) begin
        resp_owner <= winner;
        if (w_lock) begin
          lock_valid <= 1'b1;
          lock_owner <= winner;
          // Budget is only consumed while the other master is waiting.
          lock_cnt   <= (other_req && lock_base != LOCK_MAX) ? lock_base + 8'd1 : lock_base;
        end else begin
          lock_valid <= 1'b0;
          lock_owner <= M_CORE;
          lock_cnt   <= 8'd0;
        end
      end
    end
  end

  // Responses are suppressed during reset so an in-flight one is dropped.
  assign m0_rvalid_o = resp_valid & ~rst & (resp_owner == M_CORE);
  assign m1_rvalid_o = resp_valid & ~rst & (resp_owner == M_AUX);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level arbitration/memory model.
module tb_dmem_arbiter;
  localparam int MAX_LOCK = 8;

  typedef struct {
    bit          vld;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          lock;
  } txn_t;

  typedef struct {
    int          cyc;
    int          m;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [9:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, mem_we_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_wdata_o, mem_rdata;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;

  dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment data memory: byte-masked write, registered read.
  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we_o) env_mem[mem_addr_o] <= merge(env_mem[mem_addr_o], mem_wdata_o, mem_be_o);
    mem_rdata <= env_mem[mem_addr_o];
  end

  int   tests = 0, failed = 0, cyc = 0, last_w = -1;
  bit   rst_next = 1;
  txn_t p [2];
  exp_t q [$];

  // Reference arbitration state: who won last, who holds the lock and how
  // many grants it has taken while the other master was waiting.
  int m_last = 1, m_holder = -1, m_held = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic txn_t mk(bit we, logic [9:0] a, logic [31:0] d, logic [3:0] be, bit lock);
    txn_t t;
    t.vld = 1; t.we = we; t.addr = a; t.wdata = d; t.be = be; t.lock = lock;
    return t;
  endfunction

  function automatic int predict();
    if (m_holder >= 0 && p[m_holder].vld && m_held < MAX_LOCK) return m_holder;
    if (p[0].vld && !p[1].vld) return 0;
    if (p[1].vld && !p[0].vld) return 1;
    if (p[0].vld && p[1].vld) return 1 - m_last;
    return -1;
  endfunction

  task automatic tick();
    int w;
    logic [46:0] exp_bus;
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    rst = rst_next;
    m0_req = p[0].vld; m0_we = p[0].we; m0_addr = p[0].addr; m0_wdata = p[0].wdata;
    m0_be = p[0].be; m0_lock = p[0].lock;
    m1_req = p[1].vld; m1_we = p[1].we; m1_addr = p[1].addr; m1_wdata = p[1].wdata;
    m1_be = p[1].be; m1_lock = p[1].lock;
    @(negedge clk);
    if (rst) begin
      chk("reset_outputs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
                            mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, '0);
      q.delete();
      m_last = 1; m_holder = -1; m_held = 0; last_w = -1;
    end else begin
      w = predict();
      chk("gnt", {m1_gnt_o, m0_gnt_o}, (w < 0) ? 2'b00 : (w == 1) ? 2'b10 : 2'b01);
      exp_bus = (w < 0) ? '0 : {p[w].we, p[w].addr, p[w].wdata, p[w].be};
      chk("mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, exp_bus);
      last_w = m0_gnt_o ? 0 : (m1_gnt_o ? 1 : -1);
      if (w >= 0) begin
        e.cyc = cyc; e.m = w; e.rd = !p[w].we; e.data = ref_mem[p[w].addr];
        if (p[w].we) ref_mem[p[w].addr] = merge(ref_mem[p[w].addr], p[w].wdata, p[w].be);
        q.push_back(e);
        m_last = w;
        if (p[w].lock) begin
          if (m_holder != w) m_held = 0;
          if (p[1-w].vld && m_held < MAX_LOCK) m_held++;
          m_holder = w;
        end else begin
          m_holder = -1; m_held = 0;
        end
        p[w].vld = 0;
      end
    end
  endtask

  // Monitor: every response must match the oldest outstanding transfer, and
  // arrive in the cycle right after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m0_rvalid_o || m1_rvalid_o) begin
        if (q.size() == 0) chk("unexpected_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
        else begin
          e = q.pop_front();
          chk("rvalid_owner", {m1_rvalid_o, m0_rvalid_o}, (e.m == 1) ? 2'b10 : 2'b01);
          if (e.rd) chk("rdata", (e.m == 1) ? m1_rdata_o : m0_rdata_o, e.data);
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("rvalid_missing", {m1_rvalid_o, m0_rvalid_o}, (e.m == 1) ? 2'b10 : 2'b01);
      end
      if (!m0_rvalid_o) chk("rdata0_idle", m0_rdata_o, 0);
      if (!m1_rvalid_o) chk("rdata1_idle", m1_rdata_o, 0);
    end
  end

  initial begin
    int n;
    bit seen_m0;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;
    p[0] = mk(0, 0, 0, 0, 0); p[0].vld = 0;
    p[1] = p[0];

    // Reset cycles (m1 requesting to show gnt is held off).
    p[1] = mk(0, 10'h001, 0, 0, 0);
    tick(); tick();
    p[1].vld = 0;
    rst_next = 0;

    // Single core read.
    p[0] = mk(0, 10'h010, 0, 0, 0);
    tick(); tick(); tick();

    // Both request every cycle: alternation, masked write by m1.
    p[0] = mk(0, 10'h030, 0, 0, 0);
    p[1] = mk(1, 10'h030, 32'h12345678, 4'b0011, 0);
    for (int i = 0; i < 6; i++) begin
      if (!p[0].vld) p[0] = mk(0, 10'h030, 0, 0, 0);
      if (!p[1].vld) p[1] = mk(0, 10'h030, 0, 0, 0);
      tick();
    end
    while (p[0].vld || p[1].vld) tick();
    tick();

    // Lock: m1 keeps lock, m0 waits; m1 may hold MAX_LOCK grants.
    p[0] = mk(0, 10'h040, 0, 0, 0);
    tick();
    n = 0; seen_m0 = 0;
    for (int i = 0; i < 14 && !seen_m0; i++) begin
      if (!p[0].vld) p[0] = mk(0, 10'h041, 0, 0, 0);
      if (!p[1].vld) p[1] = mk(0, 10'(10'h050 + i), 0, 0, 1);
      tick();
      if (last_w == 1) n++;
      else if (last_w == 0) seen_m0 = 1;
    end
    chk("lock_run_len", n, MAX_LOCK);
    p[1].lock = 0;
    while (p[0].vld || p[1].vld) tick();
    tick();

    // Back-to-back write then read of the same word.
    p[0] = mk(1, 10'h020, 32'hA5A5A5A5, 4'b1111, 0);
    tick();
    p[0] = mk(0, 10'h020, 0, 0, 0);
    tick(); tick();

    // Reset right after a read grant; tie afterwards goes to m0.
    p[0] = mk(0, 10'h010, 0, 0, 0);
    tick();
    rst_next = 1;
    p[1] = mk(0, 10'h011, 0, 0, 0);
    tick();
    rst_next = 0;
    p[0] = mk(0, 10'h012, 0, 0, 0);
    tick();
    chk("post_reset_tie", last_w, 0);
    while (p[0].vld || p[1].vld) tick();
    tick();

    // Idle with a write payload but no request: memory must stay untouched.
    p[0] = mk(1, 10'h060, 32'hFFFF0000, 4'b1111, 0);
    p[0].vld = 0;
    for (int i = 0; i < 4; i++) tick();
    p[0] = mk(0, 10'h060, 0, 0, 0);
    tick(); tick();

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p[m].vld && $urandom_range(0, 2) != 0)
          p[m] = mk(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      tick();
    end
    p[0].vld = 0; p[1].vld = 0;
    tick(); tick();
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
